// File: rtl/issue_rat_freelist_mp_pkg.sv
// Shared sizing, reset image and popcount helper for the PRF free list.
package issue_rat_pkg;

  localparam int PRF_CNT   = 64;
  localparam int ARCH_CNT  = 32;
  localparam int FGR_CNT   = 8;
  localparam int ACQ_PORTS = 2;
  localparam int RDM_PORTS = 2;
  localparam int PRF_W     = $clog2(PRF_CNT);
  localparam int FGR_W     = $clog2(FGR_CNT);
  localparam int CNT_W     = PRF_W + 1;

  typedef logic [PRF_CNT-1:0] prf_vec_t;

  // Architectural PRFs are live at reset; everything above them starts free.
  localparam prf_vec_t RESET_FREE = {{(PRF_CNT-ARCH_CNT){1'b1}}, {ARCH_CNT{1'b0}}};

  function automatic logic [CNT_W-1:0] popcount(input prf_vec_t v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PRF_CNT; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/issue_rat_freelist_mp_if.sv
// Rename/commit side bundle of the free list: acquire, redeem, checkpoint control and status.
interface issue_rat_freelist_mp_if;
  import issue_rat_pkg::*;

  logic [RDM_PORTS*PRF_W-1:0] i_redeemed_prf;
  logic [RDM_PORTS-1:0]       i_redeemed_valid;
  logic [ACQ_PORTS*PRF_W-1:0] o_acquire_prf;
  logic [ACQ_PORTS-1:0]       o_acquire_ready;
  logic [ACQ_PORTS*FGR_W-1:0] i_acquire_fgr;
  logic [ACQ_PORTS-1:0]       i_acquire_spec;
  logic [ACQ_PORTS-1:0]       i_acquire_valid;
  logic [FGR_W-1:0]           i_commit_fgr;
  logic                       i_commit_valid;
  logic [FGR_W-1:0]           i_abandon_fgr;
  logic                       i_abandon_valid;
  logic [CNT_W-1:0]           o_free_count;
  logic                       o_err;

  modport master (
    output i_redeemed_prf, i_redeemed_valid, i_acquire_fgr, i_acquire_spec, i_acquire_valid,
    output i_commit_fgr, i_commit_valid, i_abandon_fgr, i_abandon_valid,
    input  o_acquire_prf, o_acquire_ready, o_free_count, o_err
  );

  modport slave (
    input  i_redeemed_prf, i_redeemed_valid, i_acquire_fgr, i_acquire_spec, i_acquire_valid,
    input  i_commit_fgr, i_commit_valid, i_abandon_fgr, i_abandon_valid,
    output o_acquire_prf, o_acquire_ready, o_free_count, o_err
  );

endinterface

// File: rtl/issue_rat_freelist_mp_pick.sv
// Combinational find-first-N-set-bits: slot k gets the k-th lowest set bit of i_vec.
module issue_rat_freelist_pick #(
  parameter int WIDTH = 64,
  parameter int N     = 2,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_vec,
  output logic [N*IDX_W-1:0] o_idx,
  output logic [N-1:0]       o_valid
);

  // Slots beyond the number of set bits stay invalid with a zero index.
  always_comb begin
    int seen;
    seen    = 0;
    o_idx   = '0;
    o_valid = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (i_vec[b]) begin
        for (int k = 0; k < N; k++) begin
          if (seen == k) begin
            o_idx[k*IDX_W +: IDX_W] = IDX_W'(b);
            o_valid[k]              = 1'b1;
          end
        end
        seen = seen + 1;
      end
    end
  end

endmodule

// File: rtl/issue_rat_freelist_mp.sv
// Bitmap PRF free list with per-checkpoint (FGR) tracking so an abandoned FGR
// returns all of its speculatively acquired PRFs in a single cycle.
module issue_rat_freelist_mp
  import issue_rat_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  issue_rat_freelist_mp_if.slave  bus
);

  prf_vec_t         r_free_vec;
  prf_vec_t         r_fgr_vec [FGR_CNT];
  logic [CNT_W-1:0] r_free_count;
  logic             r_err;

  logic [ACQ_PORTS*PRF_W-1:0] w_offer_prf;
  logic [ACQ_PORTS-1:0]       w_offer_rdy;
  prf_vec_t                   w_abandon_mask;
  prf_vec_t                   w_abandon_new;
  prf_vec_t                   w_acq_mask;
  prf_vec_t                   w_rdm_mask;
  prf_vec_t                   w_free_next;
  prf_vec_t                   w_fgr_next [FGR_CNT];
  logic                       w_err_set;

  issue_rat_freelist_pick #(
    .WIDTH (PRF_CNT),
    .N     (ACQ_PORTS),
    .IDX_W (PRF_W)
  ) u_pick (
    .i_vec   (r_free_vec),
    .o_idx   (w_offer_prf),
    .o_valid (w_offer_rdy)
  );

  assign bus.o_acquire_prf   = w_offer_prf;
  assign bus.o_acquire_ready = w_offer_rdy;
  assign bus.o_free_count    = r_free_count;
  assign bus.o_err           = r_err;

  // Abandon dominates: acquires hitting the abandoned FGR are dropped and its PRFs
  // cannot be redeemed in the same cycle. Only bits that were really allocated count.
  always_comb begin
    logic [PRF_W-1:0] idx;
    logic [FGR_W-1:0] tag;
    logic             dup;
    idx            = '0;
    tag            = '0;
    dup            = 1'b0;
    w_abandon_mask = bus.i_abandon_valid ? r_fgr_vec[bus.i_abandon_fgr] : '0;
    w_abandon_new  = w_abandon_mask & ~r_free_vec;
    w_acq_mask     = '0;
    w_rdm_mask     = '0;
    w_err_set      = 1'b0;
    for (int g = 0; g < FGR_CNT; g++) w_fgr_next[g] = r_fgr_vec[g];
    if (bus.i_commit_valid)  w_fgr_next[bus.i_commit_fgr]  = '0;
    if (bus.i_abandon_valid) w_fgr_next[bus.i_abandon_fgr] = '0;

    for (int k = 0; k < ACQ_PORTS; k++) begin
      idx = w_offer_prf[k*PRF_W +: PRF_W];
      tag = bus.i_acquire_fgr[k*FGR_W +: FGR_W];
      if (bus.i_acquire_valid[k] && !w_offer_rdy[k]) begin
        w_err_set = 1'b1;
      end else if (bus.i_acquire_valid[k] && !w_abandon_mask[idx] &&
                   !(bus.i_acquire_spec[k] && bus.i_abandon_valid && tag == bus.i_abandon_fgr)) begin
        w_acq_mask[idx] = 1'b1;
        if (bus.i_acquire_spec[k] && !(bus.i_commit_valid && tag == bus.i_commit_fgr))
          w_fgr_next[tag][idx] = 1'b1;
      end
    end

    for (int k = 0; k < RDM_PORTS; k++) begin
      idx = bus.i_redeemed_prf[k*PRF_W +: PRF_W];
      dup = 1'b0;
      for (int j = 0; j < k; j++)
        if (bus.i_redeemed_valid[j] && bus.i_redeemed_prf[j*PRF_W +: PRF_W] == idx) dup = 1'b1;
      if (bus.i_redeemed_valid[k]) begin
        if (r_free_vec[idx] || w_abandon_mask[idx] || dup) w_err_set = 1'b1;
        else                                               w_rdm_mask[idx] = 1'b1;
      end
    end

    w_free_next = (r_free_vec & ~w_acq_mask) | w_rdm_mask | w_abandon_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free_vec   <= RESET_FREE;
      for (int g = 0; g < FGR_CNT; g++) r_fgr_vec[g] <= '0;
      r_free_count <= CNT_W'(PRF_CNT - ARCH_CNT);
      r_err        <= 1'b0;
    end else begin
      r_free_vec   <= w_free_next;
      for (int g = 0; g < FGR_CNT; g++) r_fgr_vec[g] <= w_fgr_next[g];
      r_free_count <= r_free_count - popcount(w_acq_mask) + popcount(w_rdm_mask) + popcount(w_abandon_new);
      r_err        <= r_err | w_err_set;
    end
  end

  // Committing and abandoning the same checkpoint together is a protocol violation.
  a_commit_abandon_same: assert property (@(posedge clk) disable iff (!reset)
    !(bus.i_commit_valid && bus.i_abandon_valid && bus.i_commit_fgr == bus.i_abandon_fgr));

  a_count_matches_vec: assert property (@(posedge clk) disable iff (!reset)
    r_free_count == popcount(r_free_vec));

endmodule

// File: tb/tb_issue_rat_freelist_mp.sv
// Randomised + directed bench: a set-based reference model predicts each cycle's outputs
// into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_issue_rat_freelist_mp;
  import issue_rat_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  issue_rat_freelist_mp_if bus();

  issue_rat_freelist_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [ACQ_PORTS-1:0] ready;
    logic [PRF_W-1:0]     prf0;
    logic [PRF_W-1:0]     prf1;
    logic [CNT_W-1:0]     count;
    logic                 err;
  } exp_t;

  typedef struct {
    bit rv0, rv1;
    int rp0, rp1;
    bit av0, av1, as0, as1;
    int af0, af1;
    bit cv;
    int cf;
    bit bv;
    int bf;
  } stim_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  bit mFree [PRF_CNT];
  bit mFgr  [FGR_CNT][PRF_CNT];
  bit mErr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < PRF_CNT; i++) mFree[i] = (i >= ARCH_CNT);
    for (int g = 0; g < FGR_CNT; g++)
      for (int i = 0; i < PRF_CNT; i++) mFgr[g][i] = 1'b0;
    mErr = 1'b0;
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < PRF_CNT; i++) if (mFree[i]) n++;
    return n;
  endfunction

  function automatic void modelOffer(output int o0, output int o1, output bit [1:0] rdy);
    int n = 0;
    o0 = 0; o1 = 0; rdy = 2'b00;
    for (int i = 0; i < PRF_CNT; i++) begin
      if (mFree[i]) begin
        if (n == 0) begin o0 = i; rdy[0] = 1'b1; end
        else if (n == 1) begin o1 = i; rdy[1] = 1'b1; end
        n++;
      end
    end
  endfunction

  function automatic bit isTracked(input int p);
    for (int g = 0; g < FGR_CNT; g++) if (mFgr[g][p]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference semantics: offers from the old free set, abandon wins over acquire and
  // redeem, commit of the tag leaves the acquire untracked.
  function automatic void modelUpdate(input stim_t s, input int off0, input int off1, input bit [1:0] rdy);
    bit nFree [PRF_CNT];
    bit aban  [PRF_CNT];
    int off[2], af[2], rp[2], addTag[2], addPrf[2];
    bit av[2], as[2], rv[2], addOn[2];
    off = '{off0, off1}; af = '{s.af0, s.af1}; rp = '{s.rp0, s.rp1};
    av = '{s.av0, s.av1}; as = '{s.as0, s.as1}; rv = '{s.rv0, s.rv1};
    addOn = '{1'b0, 1'b0}; addTag = '{0, 0}; addPrf = '{0, 0};
    nFree = mFree;
    for (int i = 0; i < PRF_CNT; i++) aban[i] = s.bv ? mFgr[s.bf][i] : 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (av[k]) begin
        if (!rdy[k]) mErr = 1'b1;
        else if (!(aban[off[k]] || (as[k] && s.bv && af[k] == s.bf))) begin
          nFree[off[k]] = 1'b0;
          if (as[k] && !(s.cv && s.cf == af[k])) begin
            addOn[k] = 1'b1; addTag[k] = af[k]; addPrf[k] = off[k];
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rv[k]) begin
        if (mFree[rp[k]] || aban[rp[k]] || (k == 1 && rv[0] && rp[0] == rp[1])) mErr = 1'b1;
        else nFree[rp[k]] = 1'b1;
      end
    end
    for (int i = 0; i < PRF_CNT; i++) if (aban[i]) nFree[i] = 1'b1;
    if (s.cv) for (int i = 0; i < PRF_CNT; i++) mFgr[s.cf][i] = 1'b0;
    if (s.bv) for (int i = 0; i < PRF_CNT; i++) mFgr[s.bf][i] = 1'b0;
    for (int k = 0; k < 2; k++) if (addOn[k]) mFgr[addTag[k]][addPrf[k]] = 1'b1;
    mFree = nFree;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.rv0 = 0; s.rv1 = 0; s.rp0 = 0; s.rp1 = 0;
    s.av0 = 0; s.av1 = 0; s.as0 = 0; s.as1 = 0; s.af0 = 0; s.af1 = 0;
    s.cv = 0; s.cf = 0; s.bv = 0; s.bf = 0;
    return s;
  endfunction

  task automatic driveIdle();
    bus.i_redeemed_prf   = '0;
    bus.i_redeemed_valid = '0;
    bus.i_acquire_fgr    = '0;
    bus.i_acquire_spec   = '0;
    bus.i_acquire_valid  = '0;
    bus.i_commit_fgr     = '0;
    bus.i_commit_valid   = 1'b0;
    bus.i_abandon_fgr    = '0;
    bus.i_abandon_valid  = 1'b0;
  endtask

  // Called at posedge+1: queue the prediction for the state now visible, drive one cycle.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int o0, o1;
    bit [1:0] rdy;
    modelOffer(o0, o1, rdy);
    e.ready = rdy;
    e.prf0  = PRF_W'(o0);
    e.prf1  = PRF_W'(o1);
    e.count = CNT_W'(modelCount());
    e.err   = mErr;
    expQ.push_back(e);
    bus.i_redeemed_prf   = {PRF_W'(s.rp1), PRF_W'(s.rp0)};
    bus.i_redeemed_valid = {s.rv1, s.rv0};
    bus.i_acquire_fgr    = {FGR_W'(s.af1), FGR_W'(s.af0)};
    bus.i_acquire_spec   = {s.as1, s.as0};
    bus.i_acquire_valid  = {s.av1, s.av0};
    bus.i_commit_fgr     = FGR_W'(s.cf);
    bus.i_commit_valid   = s.cv;
    bus.i_abandon_fgr    = FGR_W'(s.bf);
    bus.i_abandon_valid  = s.bv;
    modelUpdate(s, o0, o1, rdy);
    @(posedge clk);
    #1;
    driveIdle();
  endtask

  task automatic doReset();
    driveIdle();
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_count", 32'(bus.o_free_count), 32'(PRF_CNT - ARCH_CNT));
    checkOutput("reset_ready", 32'(bus.o_acquire_ready), 32'd3);
    checkOutput("reset_err", 32'(bus.o_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sb_ready", 32'(bus.o_acquire_ready), 32'(e.ready));
        checkOutput("sb_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'(e.prf0));
        checkOutput("sb_prf1", 32'(bus.o_acquire_prf[PRF_W +: PRF_W]), 32'(e.prf1));
        checkOutput("sb_count", 32'(bus.o_free_count), 32'(e.count));
        checkOutput("sb_err", 32'(bus.o_err), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    int o0, o1, cand[$], pick;
    bit [1:0] rdy;
    driveIdle();
    @(posedge clk);
    #1;
    doReset();

    // Reset release offers 32/33, then a non-speculative double acquire.
    checkOutput("t1_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd32);
    checkOutput("t1_prf1", 32'(bus.o_acquire_prf[PRF_W +: PRF_W]), 32'd33);
    s = idleStim(); s.av0 = 1; s.av1 = 1;
    applyStimulus(s);
    checkOutput("t1_next_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd34);
    checkOutput("t1_next_count", 32'(bus.o_free_count), 32'd30);

    // Speculative acquires under FGR 3 and 5, then abandon 3 and later 5.
    s = idleStim(); s.av0 = 1; s.av1 = 1; s.as0 = 1; s.as1 = 1; s.af0 = 3; s.af1 = 3;
    applyStimulus(s);
    s = idleStim(); s.av0 = 1; s.as0 = 1; s.af0 = 5;
    applyStimulus(s);
    s = idleStim(); s.bv = 1; s.bf = 3;
    applyStimulus(s);
    checkOutput("t2_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd34);
    checkOutput("t2_prf1", 32'(bus.o_acquire_prf[PRF_W +: PRF_W]), 32'd35);
    checkOutput("t2_count", 32'(bus.o_free_count), 32'd29);
    s = idleStim(); s.av0 = 1; s.av1 = 1;
    applyStimulus(s);
    s = idleStim(); s.bv = 1; s.bf = 5;
    applyStimulus(s);
    checkOutput("t2_fgr5_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd36);
    checkOutput("t2_fgr5_count", 32'(bus.o_free_count), 32'd28);

    // Drain to exhaustion, then redeem 40.
    while (modelCount() > 2) begin
      s = idleStim(); s.av0 = 1; s.av1 = 1;
      applyStimulus(s);
    end
    s = idleStim(); s.av0 = 1;
    applyStimulus(s);
    checkOutput("t3_one_ready", 32'(bus.o_acquire_ready), 32'd1);
    checkOutput("t3_one_prf1", 32'(bus.o_acquire_prf[PRF_W +: PRF_W]), 32'd0);
    applyStimulus(s);
    checkOutput("t3_zero_ready", 32'(bus.o_acquire_ready), 32'd0);
    checkOutput("t3_zero_prf", 32'(bus.o_acquire_prf), 32'd0);
    applyStimulus(idleStim());
    checkOutput("t3_zero_count", 32'(bus.o_free_count), 32'd0);
    s = idleStim(); s.rv0 = 1; s.rp0 = 40;
    applyStimulus(s);
    checkOutput("t3_redeem_ready", 32'(bus.o_acquire_ready), 32'd1);
    checkOutput("t3_redeem_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd40);

    // Acquire racing an abandon of its own FGR, and acquire racing a commit.
    s = idleStim(); s.rv0 = 1; s.rp0 = 41; s.rv1 = 1; s.rp1 = 42;
    applyStimulus(s);
    s = idleStim(); s.av0 = 1; s.as0 = 1; s.af0 = 2; s.bv = 1; s.bf = 2;
    applyStimulus(s);
    checkOutput("t4_same_cycle_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd40);
    checkOutput("t4_same_cycle_count", 32'(bus.o_free_count), 32'd3);
    s = idleStim(); s.av0 = 1; s.as0 = 1; s.af0 = 2;
    applyStimulus(s);
    s = idleStim(); s.av0 = 1; s.as0 = 1; s.af0 = 2; s.bv = 1; s.bf = 2;
    applyStimulus(s);
    checkOutput("t4_mixed_count", 32'(bus.o_free_count), 32'd3);
    s = idleStim(); s.av0 = 1; s.as0 = 1; s.af0 = 4; s.cv = 1; s.cf = 4;
    applyStimulus(s);
    s = idleStim(); s.bv = 1; s.bf = 4;
    applyStimulus(s);
    checkOutput("t4_commit_untracked", 32'(bus.o_free_count), 32'd2);

    // Double free sets the sticky error without changing the count.
    doReset();
    s = idleStim(); s.rv0 = 1; s.rp0 = 50;
    applyStimulus(s);
    checkOutput("t5_err", 32'(bus.o_err), 32'd1);
    checkOutput("t5_count", 32'(bus.o_free_count), 32'd32);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("t5_err_sticky", 32'(bus.o_err), 32'd1);

    // Commit then abandon the same FGR frees nothing; then a random soak.
    doReset();
    s = idleStim(); s.av0 = 1; s.av1 = 1; s.as0 = 1; s.as1 = 1; s.af0 = 5; s.af1 = 5;
    applyStimulus(s);
    s = idleStim(); s.cv = 1; s.cf = 5;
    applyStimulus(s);
    s = idleStim(); s.bv = 1; s.bf = 5;
    applyStimulus(s);
    checkOutput("t6_count", 32'(bus.o_free_count), 32'd30);
    checkOutput("t6_prf0", 32'(bus.o_acquire_prf[0 +: PRF_W]), 32'd34);

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) doReset();
      s = idleStim();
      modelOffer(o0, o1, rdy);
      if (rdy[0] && $urandom_range(0, 2) != 0) begin
        s.av0 = 1; s.as0 = $urandom_range(0, 1) == 1; s.af0 = $urandom_range(0, FGR_CNT-1);
      end
      if (rdy[1] && $urandom_range(0, 2) != 0) begin
        s.av1 = 1; s.as1 = $urandom_range(0, 1) == 1; s.af1 = $urandom_range(0, FGR_CNT-1);
      end
      cand.delete();
      for (int p = 0; p < PRF_CNT; p++) if (!mFree[p] && !isTracked(p)) cand.push_back(p);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, cand.size()-1);
        s.rv0 = 1; s.rp0 = cand[pick]; cand.delete(pick);
      end
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, cand.size()-1);
        s.rv1 = 1; s.rp1 = cand[pick];
      end
      if ($urandom_range(0, 5) == 0) begin s.cv = 1; s.cf = $urandom_range(0, FGR_CNT-1); end
      if ($urandom_range(0, 5) == 0) begin s.bv = 1; s.bf = $urandom_range(0, FGR_CNT-1); end
      if (s.cv && s.bv && s.cf == s.bf) s.bv = 0;
      applyStimulus(s);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
